fetch_controller: RTL and testbench

Sequencer for the synchronous-read instruction memory. It owns the fetch PC and drives the memory's enable and address. It tracks which PC each returned word belongs to and presents {valid, pc, instr} to the decode stage. It handles stall (hold), redirect (branch/jump/trap target) and a global fetch-enable used while a program loader owns the system.

---
 rtl/fetch_controller.sv | 121 ++++++++++++
 tb/tb_fetch_controller.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller: instruction-fetch sequencer for a synchronous-read
// instruction memory (1-cycle read latency, output held while en=0).
// Owns the fetch PC, issues memory reads, and pairs each returned word with
// the PC it was fetched from for the decode stage.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   fetch_en_i       global fetch enable (low = idle, PC held)
//   stall_i          decode back-pressure; hold current output
//   redirect_i       one-cycle restart request at redirect_pc_i
//   redirect_pc_i    redirect target (low two bits ignored, flagged)
//   imem_en_o        memory read enable
//   imem_addr_o      memory byte address
//   imem_rdata_i     memory read data, valid the cycle after enable
//   if_valid_o       if_pc_o/if_instr_o carry a live fetch
//   if_pc_o          byte PC of if_instr_o
//   if_instr_o       fetched word, or NOP_INSTR when not valid
//   misalign_o       pulse: previous cycle's redirect target was misaligned
//   fetch_count_o    number of issued fetches, wraps
module fetch_controller #(
    parameter int unsigned     ALEN      = 32,
    parameter logic [ALEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en_i,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [ALEN-1:0] redirect_pc_i,
    output logic            imem_en_o,
    output logic [ALEN-1:0] imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_valid_o,
    output logic [ALEN-1:0] if_pc_o,
    output logic [31:0]     if_instr_o,
    output logic            misalign_o,
    output logic [31:0]     fetch_count_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [ALEN-1:0] pc_q, pc_d;
    logic [ALEN-1:0] out_pc_q, out_pc_d;
    logic            out_valid_q, out_valid_d;
    logic            misalign_q, misalign_d;
    logic [31:0]     count_q, count_d;

    logic [ALEN-1:0] redirect_aligned;
    logic            fetch_fire;

    assign redirect_aligned = {redirect_pc_i[ALEN-1:2], 2'b00};

    // Stall is honoured combinationally so the memory never reads past it;
    // a redirect always fetches its target immediately (zero bubble).
    assign fetch_fire  = ~rst & fetch_en_i & (redirect_i | ~stall_i);
    assign imem_en_o   = fetch_fire;
    assign imem_addr_o = redirect_i ? redirect_aligned : pc_q;

    // Next-state: disable > redirect > stall > advance.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_pc_d    = out_pc_q;
        out_valid_d = out_valid_q;
        misalign_d  = redirect_i & (|redirect_pc_i[1:0]);
        count_d     = count_q + 32'(fetch_fire);

        if (!fetch_en_i) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            if (redirect_i) begin
                pc_d = redirect_aligned;
            end
        end else if (redirect_i) begin
            state_d     = RUN;
            pc_d        = redirect_aligned + ALEN'(4);
            out_pc_d    = redirect_aligned;
            out_valid_d = 1'b1;
        end else if (stall_i) begin
            // Memory holds its output, so holding out_pc keeps the pair stable.
            state_d = HOLD;
        end else begin
            state_d     = RUN;
            pc_d        = pc_q + ALEN'(4);
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            out_pc_q    <= RESET_PC;
            out_valid_q <= 1'b0;
            misalign_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_pc_q    <= out_pc_d;
            out_valid_q <= out_valid_d;
            misalign_q  <= misalign_d;
            count_q     <= count_d;
        end
    end

    assign if_valid_o    = out_valid_q;
    assign if_pc_o       = out_pc_q;
    assign if_instr_o    = out_valid_q ? imem_rdata_i : NOP_INSTR;
    assign misalign_o    = misalign_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed plus randomized stimulus for fetch_controller,
// checked against a behavioural model of the fetch stream and a simple
// synchronous-read memory returning an address-derived pattern.
module tb_fetch_controller;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_en_o;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i = '0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;
    logic        misalign_o;
    logic [31:0] fetch_count_o;

    int checks = 0;
    int failures = 0;

    // Reference model of the fetch stream
    logic [31:0] m_pc, m_out_pc, m_cnt;
    logic        m_valid, m_mis;

    fetch_controller dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en_i    (fetch_en_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_en_o     (imem_en_o),
        .imem_addr_o   (imem_addr_o),
        .imem_rdata_i  (imem_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o),
        .misalign_o    (misalign_o),
        .fetch_count_o (fetch_count_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Synchronous-read memory: output holds while enable is low.
    always @(posedge clk) begin
        if (imem_en_o) imem_rdata_i <= word_at(imem_addr_o);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_out_pc = 32'h0; m_cnt = 0; m_valid = 1'b0; m_mis = 1'b0;
    endtask

    task automatic check_regs();
        check("if_valid", 32'(if_valid_o), 32'(m_valid));
        check("if_pc", if_pc_o, m_out_pc);
        check("if_instr", if_instr_o, m_valid ? word_at(m_out_pc) : NOP);
        check("misalign", 32'(misalign_o), 32'(m_mis));
        check("fetch_count", fetch_count_o, m_cnt);
    endtask

    // One clock cycle with the given inputs; checks fetch request and result.
    task automatic step(input logic fe, input logic st, input logic rd, input logic [31:0] rpc);
        logic [31:0] al;
        logic        en;
        @(negedge clk);
        fetch_en_i = fe; stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
        #1;
        al = rpc & 32'hFFFF_FFFC;
        en = fe & (rd | ~st);
        check("imem_en", 32'(imem_en_o), 32'(en));
        if (en) check("imem_addr", imem_addr_o, rd ? al : m_pc);
        @(posedge clk);
        if (!fe) begin
            if (rd) m_pc = al;
            m_valid = 1'b0;
        end else if (rd) begin
            m_out_pc = al; m_pc = al + 32'd4; m_valid = 1'b1;
        end else if (!st) begin
            m_out_pc = m_pc; m_pc = m_pc + 32'd4; m_valid = 1'b1;
        end
        m_mis = rd && (rpc[1:0] != 2'b00);
        if (en) m_cnt = m_cnt + 32'd1;
        #1;
        check_regs();
    endtask

    initial begin
        model_reset();
        #1;
        check("rst_imem_en", 32'(imem_en_o), 32'd0);
        check_regs();
        @(negedge clk); rst = 1'b0;

        // Straight stream from reset, then a 3-cycle stall at pc=0x10
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        check("stall_hold_pc", if_pc_o, 32'h0000_000C);
        step(1, 0, 0, 0);
        check("post_stall_pc", if_pc_o, 32'h0000_0010);
        for (int i = 0; i < 2; i++) step(1, 0, 0, 0);

        // Redirects, aligned then misaligned
        step(1, 0, 1, 32'h0000_0200);
        check("redir_pc", if_pc_o, 32'h0000_0200);
        step(1, 0, 1, 32'h0000_0202);
        check("misalign_pulse", 32'(misalign_o), 32'd1);
        step(1, 0, 0, 0);
        check("misalign_clear", 32'(misalign_o), 32'd0);

        // Redirect during stall, then stall follows
        step(1, 1, 1, 32'h0000_0080);
        check("redir_stall_pc", if_pc_o, 32'h0000_0080);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);

        // Disable at pc=0x40, re-enable resumes there
        step(1, 0, 1, 32'h0000_0038);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        check("disable_instr", if_instr_o, NOP);
        step(0, 0, 1, 32'h0000_0043);   // redirect while idle
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        check("reenable_pc", if_pc_o, 32'h0000_0040);

        // PC wrap past all-ones
        step(1, 0, 1, 32'hFFFF_FFFC);
        step(1, 0, 0, 0);
        check("wrap_pc", if_pc_o, 32'h0000_0000);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            step(($urandom % 10) != 0, ($urandom % 4) == 0, ($urandom % 8) == 0, $urandom);

        // Async reset mid-stall at pc=0x1000
        step(1, 0, 1, 32'h0000_0FFC);
        step(1, 1, 0, 0);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_en", 32'(imem_en_o), 32'd0);
        check_regs();
        @(negedge clk); rst = 1'b0;
        step(1, 0, 0, 0);
        check("post_rst_pc", if_pc_o, 32'h0000_0000);
        check("post_rst_cnt", fetch_count_o, 32'd1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
